// File: rtl/rsa_decrypt.sv
// ---------------------------------------------------------------------------
// rsa_decrypt
//   Constant-time modular exponentiation M = C^D mod N for the RSA receive
//   path. A single shared modular multiplier does all the work: one cycle for
//   the full product, then a bit-serial restoring reduction of that product
//   modulo N. The exponent is scanned LSB first. All WIDTH bits are always
//   visited and the multiply is always performed, so latency does not depend
//   on the data.
//
// Ports
//   Clk    in   rising-edge clock
//   Reset  in   asynchronous, active-high reset
//   Load   in   start request, sampled only while idle
//   C      in   ciphertext (may be >= N)
//   D      in   private exponent
//   N      in   modulus
//   M      out  plaintext result, held until the next completion
//   Done   out  one-cycle pulse when M (and Err) update
//   Busy   out  high from the cycle after Load acceptance until Done
//   Err    out  set with Done when N < 2
// ---------------------------------------------------------------------------
module rsa_decrypt #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] M,
    output logic             Done,
    output logic             Busy,
    output logic             Err
);

    localparam int PW      = 2 * WIDTH;         // full product width
    localparam int NUM_OPS = 2 * WIDTH + 1;     // reduce C, then 2 ops per exponent bit
    localparam int OP_W    = $clog2(NUM_OPS + 1);
    localparam int CNT_W   = $clog2(PW);
    localparam int IDX_W   = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RED  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [WIDTH-1:0]   d_r;
    logic [WIDTH-1:0]   n_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   base_r;
    logic [OP_W-1:0]    op_r;
    logic [PW-1:0]      p_r;
    logic [WIDTH:0]     r_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               err_r;

    logic               n_bad_s;
    logic [WIDTH-1:0]   mul_x_s;
    logic [WIDTH-1:0]   mul_y_s;
    logic [PW-1:0]      product_s;
    logic [WIDTH+1:0]   r_prime_s;
    logic [WIDTH+1:0]   r_diff_s;
    logic [WIDTH:0]     r_red_s;
    logic               last_red_s;
    logic               last_op_s;
    logic [IDX_W-1:0]   bit_idx_s;
    logic               take_bit_s;

    assign n_bad_s = (N < WIDTH'(2));

    // Operand selection for the shared multiplier: op 0 reduces C (base*1),
    // odd ops multiply result by base, even ops square the base.
    always_comb begin
        mul_x_s = base_r;
        mul_y_s = base_r;
        if (op_r == OP_W'(0)) begin
            mul_x_s = base_r;
            mul_y_s = WIDTH'(1);
        end else if (op_r[0]) begin
            mul_x_s = result_r;
            mul_y_s = base_r;
        end else begin
            mul_x_s = base_r;
            mul_y_s = base_r;
        end
    end

    assign product_s = PW'(mul_x_s) * PW'(mul_y_s);

    // One restoring-division step: shift in the next product bit, subtract N
    // when it fits. R stays below N, so R' < 2N never overflows WIDTH+1 bits.
    always_comb begin
        r_prime_s = {r_r, p_r[cnt_r]};
        r_diff_s  = r_prime_s - {2'b00, n_r};
        if (r_prime_s >= {2'b00, n_r}) begin
            r_red_s = r_diff_s[WIDTH:0];
        end else begin
            r_red_s = r_prime_s[WIDTH:0];
        end
    end

    assign last_red_s = (cnt_r == CNT_W'(0));
    assign last_op_s  = (op_r == OP_W'(NUM_OPS - 1));
    // Odd op 2i+1 handles exponent bit i.
    assign bit_idx_s  = IDX_W'(op_r >> 1);
    assign take_bit_s = d_r[bit_idx_s];

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (Load) begin
                    if (n_bad_s) begin
                        state_next_s = S_FIN;
                    end else begin
                        state_next_s = S_MUL;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_MUL: begin
                state_next_s = S_RED;
            end
            S_RED: begin
                if (last_red_s) begin
                    if (last_op_s) begin
                        state_next_s = S_FIN;
                    end else begin
                        state_next_s = S_MUL;
                    end
                end else begin
                    state_next_s = S_RED;
                end
            end
            S_FIN: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Operand latch, multiplier product, reduction and op writeback.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            d_r      <= '0;
            n_r      <= '0;
            result_r <= '0;
            base_r   <= '0;
            op_r     <= '0;
            p_r      <= '0;
            r_r      <= '0;
            cnt_r    <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (Load) begin
                        d_r    <= D;
                        n_r    <= N;
                        base_r <= C;
                        op_r   <= '0;
                        if (n_bad_s) begin
                            result_r <= '0;
                            err_r    <= 1'b1;
                        end else begin
                            result_r <= WIDTH'(1);
                            err_r    <= 1'b0;
                        end
                    end
                end
                S_MUL: begin
                    p_r   <= product_s;
                    r_r   <= '0;
                    cnt_r <= CNT_W'(PW - 1);
                end
                S_RED: begin
                    r_r   <= r_red_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (last_red_s) begin
                        op_r <= op_r + OP_W'(1);
                        if (op_r == OP_W'(0)) begin
                            base_r <= r_red_s[WIDTH-1:0];
                        end else if (op_r[0]) begin
                            // Multiply is always done; the result is only kept
                            // when the exponent bit is set.
                            if (take_bit_s) begin
                                result_r <= r_red_s[WIDTH-1:0];
                            end
                        end else begin
                            base_r <= r_red_s[WIDTH-1:0];
                        end
                    end
                end
                S_FIN: begin
                    op_r <= op_r;
                end
                default: begin
                    op_r <= op_r;
                end
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            M    <= '0;
            Done <= 1'b0;
            Busy <= 1'b0;
            Err  <= 1'b0;
        end else begin
            Done <= (state_r == S_FIN);
            Busy <= (state_r == S_MUL) || (state_r == S_RED);
            if (state_r == S_FIN) begin
                M   <= result_r;
                Err <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_rsa_decrypt.sv
// ---------------------------------------------------------------------------
// tb_rsa_decrypt
//   Self-checking bench for rsa_decrypt: directed vector table, handshake and
//   reset sequences, and random triples against a square-and-multiply model.
// ---------------------------------------------------------------------------
module tb_rsa_decrypt;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        Load  = 1'b0;
    logic [15:0] C     = 16'd0;
    logic [15:0] D     = 16'd0;
    logic [15:0] N     = 16'd0;
    logic [15:0] M;
    logic        Done;
    logic        Busy;
    logic        Err;

    int errors = 0;
    int checks = 0;

    localparam int LAT_OK  = 1090;
    localparam int LAT_ERR = 1;
    localparam int BUSY_OK = 1089;

    rsa_decrypt #(.WIDTH(16)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Load  (Load),
        .C     (C),
        .D     (D),
        .N     (N),
        .M     (M),
        .Done  (Done),
        .Busy  (Busy),
        .Err   (Err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] c;
        logic [15:0] d;
        logic [15:0] n;
        logic [15:0] m;
        bit          err;
    } vec_t;

    vec_t vecs[10];

    // Reference: plain square-and-multiply on 64-bit integers.
    function automatic logic [15:0] modpow(input logic [15:0] c, input logic [15:0] d,
                                           input logic [15:0] n);
        longint unsigned r, b, e, nn;
        nn = longint'(n);
        r  = 1;
        b  = longint'(c) % nn;
        e  = longint'(d);
        while (e != 0) begin
            if (e[0]) r = (r * b) % nn;
            b = (b * b) % nn;
            e = e >> 1;
        end
        r = r % nn;
        return r[15:0];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Start one run and watch it to completion (bounded); optionally pulse a
    // second Load with other operands at t0+500.
    task automatic run_op(input logic [15:0] c, input logic [15:0] d, input logic [15:0] n,
                          input bit mid_load,
                          output logic [15:0] m, output logic err, output int lat,
                          output int busy_cnt, output bit done_narrow);
        bit found;
        @(negedge Clk);
        C = c; D = d; N = n; Load = 1'b1;
        @(posedge Clk);           // t0
        #1;
        Load = 1'b0;
        C = 16'($urandom); D = 16'($urandom); N = 16'($urandom);
        found = 1'b0; lat = -1; busy_cnt = 0; m = 16'hxxxx; err = 1'bx;
        for (int k = 1; k <= 1200 && !found; k++) begin
            @(posedge Clk);
            #1;
            if (Busy) busy_cnt++;
            if (Done) begin
                found = 1'b1;
                lat   = k;
                m     = M;
                err   = Err;
            end
            if (mid_load && k == 499) begin
                Load = 1'b1; C = 16'd17; D = 16'd3; N = 16'd101;
            end else if (mid_load && k == 500) begin
                Load = 1'b0;
            end
        end
        @(posedge Clk);
        #1;
        done_narrow = !Done;
    endtask

    task automatic check_run(input string name, input logic [15:0] c, input logic [15:0] d,
                             input logic [15:0] n, input logic [15:0] exp_m, input bit exp_err,
                             input bit mid_load);
        logic [15:0] m;
        logic        err;
        int          lat, busy_cnt;
        bit          narrow;
        run_op(c, d, n, mid_load, m, err, lat, busy_cnt, narrow);
        check({name, ".M"},       64'(m),        64'(exp_m));
        check({name, ".Err"},     64'(err),      64'(exp_err));
        check({name, ".latency"}, 64'(lat),      exp_err ? 64'(LAT_ERR) : 64'(LAT_OK));
        check({name, ".busy"},    64'(busy_cnt), exp_err ? 64'd0 : 64'(BUSY_OK));
        check({name, ".done1"},   64'(narrow),   64'd1);
    endtask

    initial begin
        vecs[0] = '{16'd2790,  16'd2753,  16'd3233,  16'd65,    1'b0};
        vecs[1] = '{16'd3238,  16'd1,     16'd3233,  16'd5,     1'b0};
        vecs[2] = '{16'd1234,  16'd0,     16'd3233,  16'd1,     1'b0};
        vecs[3] = '{16'd0,     16'd7,     16'd3233,  16'd0,     1'b0};
        vecs[4] = '{16'd65534, 16'd3,     16'd65535, 16'd65534, 1'b0};
        vecs[5] = '{16'd65534, 16'd2,     16'd65535, 16'd1,     1'b0};
        vecs[6] = '{16'd65535, 16'd65535, 16'd65521,
                    modpow(16'd65535, 16'd65535, 16'd65521), 1'b0};
        vecs[7] = '{16'd1234,  16'd5,     16'd1,     16'd0,     1'b1};
        vecs[8] = '{16'd999,   16'd0,     16'd0,     16'd0,     1'b1};
        vecs[9] = '{16'd0,     16'd0,     16'd3233,  16'd1,     1'b0};

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        check("reset.M",    64'(M),    64'd0);
        check("reset.Done", 64'(Done), 64'd0);
        check("reset.Busy", 64'(Busy), 64'd0);
        check("reset.Err",  64'(Err),  64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            check_run($sformatf("vec%0d", i), vecs[i].c, vecs[i].d, vecs[i].n,
                      vecs[i].m, vecs[i].err, 1'b0);
        end

        // Load while busy is ignored
        check_run("midload", 16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, 1'b1);

        // Asynchronous reset mid-run (M currently holds 65 from the run above)
        begin
            @(negedge Clk);
            C = 16'd1234; D = 16'd5; N = 16'd3233; Load = 1'b1;
            @(posedge Clk);
            #1;
            Load = 1'b0;
            repeat (699) @(posedge Clk);
            #1;
            check("prereset.Busy", 64'(Busy), 64'd1);
            Reset = 1'b1;
            #1;
            check("midreset.M",    64'(M),    64'd0);
            check("midreset.Busy", 64'(Busy), 64'd0);
            check("midreset.Done", 64'(Done), 64'd0);
            @(negedge Clk);
            Reset = 1'b0;
            check_run("postreset", 16'd2790, 16'd2753, 16'd3233, 16'd65, 1'b0, 1'b0);
        end

        // Load held high: back-to-back runs one every 1091 cycles
        begin
            int d1, d2;
            logic [15:0] m1, m2;
            d1 = -1; d2 = -1; m1 = 16'd0; m2 = 16'd0;
            @(negedge Clk);
            C = 16'd2790; D = 16'd2753; N = 16'd3233; Load = 1'b1;
            for (int k = 0; k < 2500 && d2 < 0; k++) begin
                @(posedge Clk);
                #1;
                if (Done) begin
                    if (d1 < 0) begin
                        d1 = k; m1 = M;
                    end else begin
                        d2 = k; m2 = M;
                        Load = 1'b0;
                    end
                end
            end
            Load = 1'b0;
            check("b2b.first",  64'(d1),      64'(LAT_OK));
            check("b2b.period", 64'(d2 - d1), 64'd1091);
            check("b2b.M1",     64'(m1),      64'd65);
            check("b2b.M2",     64'(m2),      64'd65);
            @(posedge Clk);
            #1;
            check("b2b.idle", 64'(Busy), 64'd0);
        end

        // Random regression against the model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] rc, rd, rn;
            rc = 16'($urandom);
            rd = 16'($urandom);
            rn = 16'($urandom_range(65535, 2));
            check_run($sformatf("rand%0d", i), rc, rd, rn, modpow(rc, rd, rn), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
